mul_sched: RTL and testbench

- Shares one sequential shift-add multiplier between two requesters.
- Requesters use valid/ready handshakes. Arbitration between them is round-robin.
- Latches the winning operands, holds Mul_Run until Mul_Ready, captures the product and returns it tagged with the requester ID.
- Sits between the CPU-side issue logic and the multiplier's Control/datapath pair.

---
 rtl/mul_sched_pkg.sv | 17 +
 rtl/mul_sched_rr_arb2.sv | 37 +++
 rtl/mul_sched.sv | 165 ++++++++++++++++
 tb/tb_mul_sched.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mul_sched_pkg.sv
// Shared types and constants for the mul_sched multiplier scheduler.
package mul_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        BUSY = 2'd2,
        RESP = 2'd3
    } state_e;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_TIMEOUT = 40;

endpackage

// File: rtl/mul_sched_rr_arb2.sv
// Two-input round-robin arbiter: combinational grant plus the last-grant flop.
module rr_arb2
    import mul_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       update,
    output logic [1:0] grant,
    output logic       grant_id
);

    logic last_grant_q, last_grant_d;

    always_comb begin
        grant_id = REQ1;
        if (valid == 2'b11)
            grant_id = ~last_grant_q;
        else if (valid[0])
            grant_id = REQ0;

        grant = 2'b00;
        if (valid != 2'b00)
            grant = (grant_id == REQ1) ? 2'b10 : 2'b01;

        last_grant_d = update ? grant_id : last_grant_q;
    end

    // Reset to REQ1 so requester 0 wins the first contested round.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_grant_q <= REQ1;
        else
            last_grant_q <= last_grant_d;
    end

endmodule

// File: rtl/mul_sched.sv
// Shares one sequential multiplier between two requesters (round-robin).
// Optional abort on a stuck multiplier: define MUL_SCHED_TIMEOUT_EN.
module mul_sched
    import mul_sched_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic               clk,
    input  logic               Reset,
    input  logic               Req0_valid,
    output logic               Req0_ready,
    input  logic [WIDTH-1:0]   Req0_A,
    input  logic [WIDTH-1:0]   Req0_B,
    input  logic               Req1_valid,
    output logic               Req1_ready,
    input  logic [WIDTH-1:0]   Req1_A,
    input  logic [WIDTH-1:0]   Req1_B,
    output logic               Rsp_valid,
    input  logic               Rsp_ready,
    output logic               Rsp_id,
    output logic [2*WIDTH-1:0] Rsp_product,
    output logic               Rsp_err,
    output logic               Mul_Run,
    output logic [WIDTH-1:0]   Mul_A,
    output logic [WIDTH-1:0]   Mul_B,
    input  logic               Mul_Ready,
    input  logic [2*WIDTH-1:0] Mul_Product,
    output logic               Busy
);

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     mul_a_q, mul_a_d;
    logic [WIDTH-1:0]     mul_b_q, mul_b_d;
    logic                 rsp_id_q, rsp_id_d;
    logic [2*WIDTH-1:0]   rsp_product_q, rsp_product_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 mul_run_q, mul_run_d;
`ifdef MUL_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 rsp_err_q, rsp_err_d;
`endif

    logic [1:0] grant;
    logic       grant_id;
    logic       accept;

    // Reset gates the grant so both readies read 0 while Reset is held low.
    assign accept = (state_q == IDLE) && Reset && (grant != 2'b00);

    rr_arb2 u_arb (
        .clk      (clk),
        .rst_n    (Reset),
        .valid    ({Req1_valid, Req0_valid}),
        .update   (accept),
        .grant    (grant),
        .grant_id (grant_id)
    );

    assign Req0_ready  = accept && grant[0];
    assign Req1_ready  = accept && grant[1];
    assign Busy        = (state_q != IDLE);
    assign Mul_Run     = mul_run_q;
    assign Mul_A       = mul_a_q;
    assign Mul_B       = mul_b_q;
    assign Rsp_valid   = rsp_valid_q;
    assign Rsp_id      = rsp_id_q;
    assign Rsp_product = rsp_product_q;
`ifdef MUL_SCHED_TIMEOUT_EN
    assign Rsp_err     = rsp_err_q;
`else
    assign Rsp_err     = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        mul_a_d       = mul_a_q;
        mul_b_d       = mul_b_q;
        rsp_id_d      = rsp_id_q;
        rsp_product_d = rsp_product_q;
        rsp_valid_d   = rsp_valid_q;
        mul_run_d     = mul_run_q;
`ifdef MUL_SCHED_TIMEOUT_EN
        cnt_d         = cnt_q;
        rsp_err_d     = rsp_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    mul_a_d   = (grant_id == REQ1) ? Req1_A : Req0_A;
                    mul_b_d   = (grant_id == REQ1) ? Req1_B : Req0_B;
                    rsp_id_d  = grant_id;
                    mul_run_d = 1'b1;
                    state_d   = LOAD;
                end
            end
            // Mul_Ready seen here is left over from the previous operation.
            LOAD: begin
                state_d = BUSY;
`ifdef MUL_SCHED_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            BUSY: begin
                if (Mul_Ready) begin
                    rsp_product_d = Mul_Product;
                    mul_run_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = RESP;
                end
`ifdef MUL_SCHED_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rsp_product_d = '0;
                    rsp_err_d     = 1'b1;
                    mul_run_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RESP: begin
                if (Rsp_ready) begin
                    rsp_valid_d = 1'b0;
`ifdef MUL_SCHED_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
`endif
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q       <= IDLE;
            mul_a_q       <= '0;
            mul_b_q       <= '0;
            rsp_id_q      <= 1'b0;
            rsp_product_q <= '0;
            rsp_valid_q   <= 1'b0;
            mul_run_q     <= 1'b0;
`ifdef MUL_SCHED_TIMEOUT_EN
            cnt_q         <= '0;
            rsp_err_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            mul_a_q       <= mul_a_d;
            mul_b_q       <= mul_b_d;
            rsp_id_q      <= rsp_id_d;
            rsp_product_q <= rsp_product_d;
            rsp_valid_q   <= rsp_valid_d;
            mul_run_q     <= mul_run_d;
`ifdef MUL_SCHED_TIMEOUT_EN
            cnt_q         <= cnt_d;
            rsp_err_q     <= rsp_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_mul_sched.sv
// Directed bench for mul_sched with a latency-programmable multiplier model.
module tb_mul_sched;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          Reset;
    logic          Req0_valid, Req1_valid;
    logic          Req0_ready, Req1_ready;
    logic [W-1:0]  Req0_A, Req0_B, Req1_A, Req1_B;
    logic          Rsp_valid, Rsp_ready, Rsp_id, Rsp_err;
    logic [2*W-1:0] Rsp_product;
    logic          Mul_Run, Mul_Ready, Busy;
    logic [W-1:0]  Mul_A, Mul_B;
    logic [2*W-1:0] Mul_Product;

    int            total = 0;
    int            bad = 0;

    // Multiplier model: Ready once Run has been high for `lat` prior edges,
    // or a directly forced Ready/product when force_en is set.
    int            lat = 4;
    int            mcnt = 0;
    logic          force_en = 1'b0;
    logic          force_val = 1'b0;
    logic [2*W-1:0] force_prod = '0;

    always #5 clk = ~clk;

    always @(posedge clk) mcnt <= Mul_Run ? mcnt + 1 : 0;

    assign Mul_Ready   = force_en ? force_val : (Mul_Run && (mcnt == lat));
    assign Mul_Product = force_en ? force_prod : ({{W{1'b0}}, Mul_A} * {{W{1'b0}}, Mul_B});

    mul_sched #(.WIDTH(W), .TIMEOUT(40)) dut (
        .clk(clk), .Reset(Reset),
        .Req0_valid(Req0_valid), .Req0_ready(Req0_ready), .Req0_A(Req0_A), .Req0_B(Req0_B),
        .Req1_valid(Req1_valid), .Req1_ready(Req1_ready), .Req1_A(Req1_A), .Req1_B(Req1_B),
        .Rsp_valid(Rsp_valid), .Rsp_ready(Rsp_ready), .Rsp_id(Rsp_id),
        .Rsp_product(Rsp_product), .Rsp_err(Rsp_err),
        .Mul_Run(Mul_Run), .Mul_A(Mul_A), .Mul_B(Mul_B),
        .Mul_Ready(Mul_Ready), .Mul_Product(Mul_Product), .Busy(Busy)
    );

    task automatic chk(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Counts negedges with Mul_Run high until Rsp_valid; drops valids in LOAD unless keep.
    task automatic wait_rsp(input bit keep, output int runs);
        bit got;
        runs = 0;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (i == 0 && !keep) begin
                Req0_valid = 1'b0;
                Req1_valid = 1'b0;
            end
            if (Mul_Run) runs++;
            if (Rsp_valid) got = 1'b1;
        end
        chk("rsp_wait_bound", {63'd0, got}, 64'd1);
    endtask

    task automatic handshake();
        Rsp_ready = 1'b1;
        @(negedge clk);
        Rsp_ready = 1'b0;
        chk("rsp_valid_cleared", {63'd0, Rsp_valid}, 64'd0);
    endtask

    initial begin
        int runs;
        logic [2*W-1:0] held;
        logic [1:0] exp_id;

        Reset = 1'b0;
        Req0_valid = 1'b0; Req1_valid = 1'b0;
        Req0_A = '0; Req0_B = '0; Req1_A = '0; Req1_B = '0;
        Rsp_ready = 1'b0;

        // Reset state, with a requester already asserting valid
        repeat (2) @(negedge clk);
        Req0_valid = 1'b1;
        #1;
        chk("rst_ready0", {63'd0, Req0_ready}, 64'd0);
        chk("rst_busy", {63'd0, Busy}, 64'd0);
        chk("rst_run", {63'd0, Mul_Run}, 64'd0);
        chk("rst_rsp_valid", {63'd0, Rsp_valid}, 64'd0);
        chk("rst_product", Rsp_product, 64'd0);
        Req0_valid = 1'b0;

        // Start an operation then pull reset mid-BUSY
        @(negedge clk);
        Reset = 1'b1;
        lat = 32;
        Req0_A = 32'd7; Req0_B = 32'd9; Req0_valid = 1'b1;
        repeat (2) @(negedge clk);
        Req0_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("midbusy_run", {63'd0, Mul_Run}, 64'd1);
        #2 Reset = 1'b0;
        #1;
        chk("async_rst_run", {63'd0, Mul_Run}, 64'd0);
        chk("async_rst_busy", {63'd0, Busy}, 64'd0);
        chk("async_rst_mul_a", {32'd0, Mul_A}, 64'd0);
        chk("async_rst_mul_b", {32'd0, Mul_B}, 64'd0);
        chk("async_rst_rsp_valid", {63'd0, Rsp_valid}, 64'd0);
        @(negedge clk);
        Reset = 1'b1;

        // First grant after reset goes to requester 0
        lat = 4;
        Req0_A = 32'd3; Req0_B = 32'd5; Req0_valid = 1'b1;
        #1;
        chk("first_grant_r0", {63'd0, Req0_ready}, 64'd1);
        wait_rsp(1'b0, runs);
        chk("t1_product", Rsp_product, 64'd15);
        chk("t1_id", {63'd0, Rsp_id}, 64'd0);
        chk("t1_err", {63'd0, Rsp_err}, 64'd0);
        chk("t1_run_low", {63'd0, Mul_Run}, 64'd0);
        handshake();

        // Single request on requester 1, 32-cycle multiplier
        lat = 32;
        Req1_A = 32'hFFFF_FFFF; Req1_B = 32'd2; Req1_valid = 1'b1;
        #1;
        chk("t2_ready1", {63'd0, Req1_ready}, 64'd1);
        wait_rsp(1'b0, runs);
        chk("t2_run_cycles", 64'(runs), 64'd33);
        chk("t2_product", Rsp_product, 64'h1_FFFF_FFFE);
        chk("t2_id", {63'd0, Rsp_id}, 64'd1);
        handshake();

        // Both valid continuously: strict alternation 0,1,0,1
        lat = 4;
        Req0_A = 32'd10; Req0_B = 32'd11;
        Req1_A = 32'd20; Req1_B = 32'd21;
        Req0_valid = 1'b1; Req1_valid = 1'b1;
        #1;
        chk("alt_ready0", {63'd0, Req0_ready}, 64'd1);
        chk("alt_ready1_low", {63'd0, Req1_ready}, 64'd0);
        for (int k = 0; k < 4; k++) begin
            exp_id = 2'(k % 2);
            wait_rsp(1'b1, runs);
            chk("alt_id", {63'd0, Rsp_id}, {63'd0, exp_id[0]});
            chk("alt_product", Rsp_product, exp_id[0] ? 64'd420 : 64'd110);
            handshake();
        end

        // Consumer stalls 5 cycles in RESP
        wait_rsp(1'b1, runs);
        chk("stall_id", {63'd0, Rsp_id}, 64'd0);
        held = Rsp_product;
        chk("stall_product0", held, 64'd110);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_valid", {63'd0, Rsp_valid}, 64'd1);
            chk("stall_product", Rsp_product, 64'd110);
            chk("stall_no_ready", {62'd0, Req1_ready, Req0_ready}, 64'd0);
        end
        handshake();
        chk("post_hs_ready1", {63'd0, Req1_ready}, 64'd1);
        chk("post_hs_ready0", {63'd0, Req0_ready}, 64'd0);
        Req0_valid = 1'b0; Req1_valid = 1'b0;
        @(negedge clk);
        chk("idle_after_drop", {63'd0, Busy}, 64'd0);

        // Stale Ready during LOAD must be ignored
        force_en = 1'b1; force_val = 1'b1; force_prod = 64'hDEAD;
        Req0_A = 32'd6; Req0_B = 32'd7; Req0_valid = 1'b1;
        @(negedge clk);
        Req0_valid = 1'b0;
        chk("stale_load_run", {63'd0, Mul_Run}, 64'd1);
        @(negedge clk);
        chk("stale_not_captured", {63'd0, Rsp_valid}, 64'd0);
        chk("stale_busy_run", {63'd0, Mul_Run}, 64'd1);
        force_val = 1'b0; force_prod = 64'd42;
        repeat (10) @(negedge clk);
        chk("stale_still_waiting", {63'd0, Rsp_valid}, 64'd0);
        force_val = 1'b1;
        @(negedge clk);
        chk("late_valid", {63'd0, Rsp_valid}, 64'd1);
        chk("late_product", Rsp_product, 64'd42);
        chk("late_run_low", {63'd0, Mul_Run}, 64'd0);
        force_val = 1'b0;
        handshake();

`ifdef MUL_SCHED_TIMEOUT_EN
        // Multiplier never answers: abort after 40 BUSY cycles
        force_prod = 64'h1234;
        Req1_A = 32'd1; Req1_B = 32'd1; Req1_valid = 1'b1;
        wait_rsp(1'b0, runs);
        chk("to_run_cycles", 64'(runs), 64'd41);
        chk("to_err", {63'd0, Rsp_err}, 64'd1);
        chk("to_product", Rsp_product, 64'd0);
        chk("to_run_low", {63'd0, Mul_Run}, 64'd0);
        handshake();
        chk("to_err_cleared", {63'd0, Rsp_err}, 64'd0);
`endif
        force_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
